dmem_io_responder: RTL and testbench

- Memory-mapped I/O responder on the processor's dmem bus; the processor is the initiator, this block is the target.
- Decodes accesses in a small address window and serves them:
  - GPIO register file: output, direction and synchronized input for the 16 io_pins.
  - Ultrasonic ranger engine: trigger pulse plus echo-width timer.
- Sits beside data RAM in the wrapper. Its io_hit output steers the wrapper's q_dmem mux between RAM and this block.

---
 rtl/io_pkg.sv | 14 +
 rtl/sonar_ranger.sv | 92 +++++++++
 rtl/dmem_io_responder.sv | 89 ++++++++
 tb/tb_dmem_io_responder.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// io_pkg: register offsets, CTRL bit positions and ranger FSM encoding for dmem_io_responder.
package io_pkg;
  localparam logic [2:0] OFF_GPIO_OUT     = 3'd0;
  localparam logic [2:0] OFF_GPIO_DIR     = 3'd1;
  localparam logic [2:0] OFF_GPIO_IN      = 3'd2;
  localparam logic [2:0] OFF_SONAR_CTRL   = 3'd3;
  localparam logic [2:0] OFF_SONAR_RESULT = 3'd4;
  localparam int CTRL_START   = 0;
  localparam int CTRL_BUSY    = 0;
  localparam int CTRL_DONE    = 1;
  localparam int CTRL_TIMEOUT = 2;
  localparam int CTRL_IRQ_EN  = 1;
  typedef enum logic [1:0] {S_IDLE, S_TRIG, S_WAIT_RISE, S_MEASURE} sonar_state_t;
endpackage

// File: rtl/sonar_ranger.sv
// sonar_ranger: ultrasonic trigger pulse, echo-width counter and timeout FSM.
module sonar_ranger #(
  parameter int TRIG_CYCLES    = 500,
  parameter int TIMEOUT_CYCLES = 1_500_000,
  parameter int CNT_W          = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clr,
  input  logic             echo,
  output logic             trig,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] result
);
  import io_pkg::*;
  localparam int TMAX = TRIG_CYCLES > TIMEOUT_CYCLES ? TRIG_CYCLES : TIMEOUT_CYCLES;
  localparam int TW = $clog2(TMAX + 1);
  localparam logic [TW-1:0] TRIG_LAST = TW'(TRIG_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  sonar_state_t state, state_n;
  logic [TW-1:0] tmr, tmr_n;
  logic [CNT_W-1:0] cnt, cnt_n, result_n;
  logic done_n, timeout_n;
  assign trig = state == S_TRIG;
  assign busy = state != S_IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= S_IDLE;
      tmr     <= '0;
      cnt     <= '0;
      result  <= '0;
      done    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_n;
      tmr     <= tmr_n;
      cnt     <= cnt_n;
      result  <= result_n;
      done    <= done_n;
      timeout <= timeout_n;
    end
  // A start write overrides a same-cycle flag clear; a finishing measurement overrides it too.
  always_comb begin
    state_n   = state;
    tmr_n     = tmr + 1'b1;
    cnt_n     = cnt;
    result_n  = result;
    done_n    = done & ~clr;
    timeout_n = timeout & ~clr;
    case (state)
      S_IDLE: begin
        tmr_n = '0;
        if (start) begin
          state_n   = S_TRIG;
          done_n    = 1'b0;
          timeout_n = 1'b0;
          result_n  = '0;
        end
      end
      S_TRIG:
        if (tmr == TRIG_LAST) begin
          state_n = S_WAIT_RISE;
          tmr_n   = '0;
        end
      // The clock that detects the rising edge is already an echo-high clock, so counting starts at 1.
      S_WAIT_RISE:
        if (echo) begin
          state_n = S_MEASURE;
          tmr_n   = '0;
          cnt_n   = CNT_W'(1);
        end else if (tmr == TO_LAST) begin
          state_n   = S_IDLE;
          timeout_n = 1'b1;
          result_n  = '0;
        end
      S_MEASURE:
        if (!echo) begin
          state_n  = S_IDLE;
          done_n   = 1'b1;
          result_n = cnt;
        end else if (tmr == TO_LAST) begin
          state_n   = S_IDLE;
          timeout_n = 1'b1;
          result_n  = '1;
        end else cnt_n = &cnt ? cnt : cnt + 1'b1;
      default: state_n = S_IDLE;
    endcase
  end
endmodule

// File: rtl/dmem_io_responder.sv
// dmem_io_responder: dmem-bus target serving GPIO registers and the ultrasonic ranger.
// Define DMEM_IO_IRQ_EN to add the irq output and the CTRL interrupt-enable bit.
module dmem_io_responder #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_1000,
  parameter int          TRIG_CYCLES    = 500,
  parameter int          TIMEOUT_CYCLES = 1_500_000,
  parameter int          CNT_W          = 24
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address_dmem,
  input  logic [31:0] data,
  input  logic        wren,
  output logic [31:0] q_dmem,
  output logic        io_hit,
  inout  wire  [15:0] io_pins,
  output logic        sonar_trig,
  input  logic        sonar_echo
`ifdef DMEM_IO_IRQ_EN
  ,
  output logic        irq
`endif
);
  import io_pkg::*;
  logic hit, wr, start, rd_clr, busy, done, timeout, echo_s1, echo_s2;
  logic [2:0] off;
  logic [15:0] gpio_out, gpio_dir, gin_s1, gin_s2;
  logic [CNT_W-1:0] result;
  logic [31:0] rdata;
  wire unused_data = &{1'b0, data[31:16]};
  assign hit    = (address_dmem - BASE_ADDR) < 32'd8;
  assign off    = address_dmem[2:0];
  assign wr     = wren && hit;
  assign start  = wr && off == OFF_SONAR_CTRL && data[CTRL_START];
  assign rd_clr = hit && !wren && off == OFF_SONAR_RESULT;
  assign rdata = off == OFF_GPIO_OUT     ? {16'h0, gpio_out} :
                 off == OFF_GPIO_DIR     ? {16'h0, gpio_dir} :
                 off == OFF_GPIO_IN      ? {16'h0, gin_s2} :
                 off == OFF_SONAR_CTRL   ? {29'h0, timeout, done, busy} :
                 off == OFF_SONAR_RESULT ? 32'(result) : 32'h0;
  for (genvar i = 0; i < 16; i++) begin : g_pin
    assign io_pins[i] = gpio_dir[i] ? gpio_out[i] : 1'bz;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      gpio_out <= '0;
      gpio_dir <= '0;
      gin_s1   <= '0;
      gin_s2   <= '0;
      echo_s1  <= 1'b0;
      echo_s2  <= 1'b0;
      q_dmem   <= '0;
      io_hit   <= 1'b0;
    end else begin
      if (wr && off == OFF_GPIO_OUT) gpio_out <= data[15:0];
      if (wr && off == OFF_GPIO_DIR) gpio_dir <= data[15:0];
      {gin_s2, gin_s1}   <= {gin_s1, io_pins};
      {echo_s2, echo_s1} <= {echo_s1, sonar_echo};
      q_dmem <= hit ? rdata : '0;
      io_hit <= hit;
    end
`ifdef DMEM_IO_IRQ_EN
  logic irq_en;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (wr && off == OFF_SONAR_CTRL) irq_en <= data[CTRL_IRQ_EN];
      irq <= (done | timeout) & irq_en;
    end
`endif
  sonar_ranger #(
    .TRIG_CYCLES   (TRIG_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_sonar (
    .clk    (clock),
    .rst_n  (reset),
    .start  (start),
    .clr    (rd_clr),
    .echo   (echo_s2),
    .trig   (sonar_trig),
    .busy   (busy),
    .done   (done),
    .timeout(timeout),
    .result (result)
  );
endmodule

// File: tb/tb_dmem_io_responder.sv
// tb_dmem_io_responder: scoreboard bench for GPIO decode and ranger measurements.
module tb_dmem_io_responder;
  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int TRIG = 500, TMO = 1200;
  logic clock = 0, reset = 0, wren = 0, sonar_echo = 0, io_hit, sonar_trig, ext_en = 0;
  logic [31:0] address_dmem = 0, data = 0, q_dmem;
  logic [7:0] ext_val = 0;
  wire [15:0] io_pins;
  int total = 0, bad = 0;
  logic [32:0] sb_v[$];
  string sb_n[$];
  assign io_pins[15:8] = ext_en ? ext_val : 8'hzz;
`ifdef DMEM_IO_IRQ_EN
  logic irq;
`endif
  always #5 clock = ~clock;
  dmem_io_responder #(.BASE_ADDR(BASE), .TRIG_CYCLES(TRIG), .TIMEOUT_CYCLES(TMO), .CNT_W(24)) dut (
    .clock(clock), .reset(reset), .address_dmem(address_dmem), .data(data), .wren(wren),
    .q_dmem(q_dmem), .io_hit(io_hit), .io_pins(io_pins), .sonar_trig(sonar_trig), .sonar_echo(sonar_echo)
`ifdef DMEM_IO_IRQ_EN
    , .irq(irq)
`endif
  );
  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask
  always @(negedge clock)
    if (sb_v.size() > 0) begin
      logic [32:0] v;
      string n;
      v = sb_v.pop_front();
      n = sb_n.pop_front();
      total++;
      if ({io_hit, q_dmem} !== v) begin
        bad++;
        $display("FAIL %s: got hit=%0b q=%h want hit=%0b q=%h", n, io_hit, q_dmem, v[32], v[31:0]);
      end
    end
  task automatic step(int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask
  task automatic wr(logic [2:0] off, logic [31:0] d);
    address_dmem = BASE + 32'(off);
    data = d;
    wren = 1;
    step();
    wren = 0;
    address_dmem = 0;
  endtask
  task automatic rd(string nm, logic [31:0] a, logic hit_e, logic [31:0] q_e);
    address_dmem = a;
    wren = 0;
    step();
    address_dmem = 0;
    sb_v.push_back({hit_e, q_e});
    sb_n.push_back(nm);
  endtask
  // Start a measurement, check the trigger width, then drive an echo pulse of the given width.
  task automatic measure(int dly, int width, bit dbl, logic [31:0] sw);
    int hi = 0;
    wr(3, sw);
    while (sonar_trig && hi < TRIG + 10) begin
      step();
      hi++;
    end
    chk("trig_width", 32'(hi), 32'(TRIG));
    step(dly);
    if (width > 0) begin
      sonar_echo = 1;
      for (int i = 0; i < width; i++)
        if (dbl && i == width / 2) wr(3, 1);
        else step();
      sonar_echo = 0;
    end
    step(6);
  endtask
  task automatic expect_flags(logic [31:0] ctrl, logic [31:0] res);
    rd("ctrl_flags", BASE + 3, 1, ctrl);
    rd("result", BASE + 4, 1, res);
    rd("ctrl_cleared", BASE + 3, 1, 0);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [31:0] v;
    logic [7:0] e;
    int w;
    step(3);
    chk("rst_hit", {31'h0, io_hit}, 0);
    chk("rst_q", q_dmem, 0);
    chk("rst_trig", {31'h0, sonar_trig}, 0);
    reset = 1;
    foreach (sb_v[i]) ;
    for (int o = 0; o < 8; o++) if (o != 2) rd("rst_reg", BASE + 32'(o), 1, 0);
    wr(1, 32'h0000_00FF);
    wr(0, 32'h0000_A55A);
    ext_en = 1;
    ext_val = 8'h3C;
    step(3);
    chk("pins_low", {24'h0, io_pins[7:0]}, 32'h5A);
    rd("gpio_in", BASE + 2, 1, 32'h3C5A);
    rd("gpio_out", BASE + 0, 1, 32'hA55A);
    rd("gpio_dir", BASE + 1, 1, 32'h00FF);
    rd("miss_hi", BASE + 8, 0, 0);
    rd("miss_lo", BASE - 1, 0, 0);
    wr(2, 32'hFFFF_FFFF);
    rd("gpio_in_ro", BASE + 2, 1, 32'h3C5A);
    for (int o = 5; o < 8; o++) rd("unmapped", BASE + 32'(o), 1, 0);
    for (int k = 0; k < 8; k++) begin
      v = $urandom;
      e = 8'($urandom);
      wr(0, v);
      ext_val = e;
      step(3);
      chk("pins_rand", {24'h0, io_pins[7:0]}, {24'h0, v[7:0]});
      rd("gpio_in_rand", BASE + 2, 1, {16'h0, e, v[7:0]});
      rd("gpio_out_rand", BASE, 1, {16'h0, v[15:0]});
      rd("miss_rand", BASE + 8 + ($urandom % 4096), 0, 0);
    end
    measure(3, 1000, 0, 1);
    expect_flags(32'h2, 1000);
    for (int k = 0; k < 5; k++) begin
      w = $urandom_range(1, 300);
      measure($urandom_range(3, 200), w, 0, 1);
      expect_flags(32'h2, 32'(w));
    end
    measure(10, 200, 1, 1);
    expect_flags(32'h2, 200);
    measure(0, 0, 0, 1);
    rd("ctrl_busy", BASE + 3, 1, 32'h1);
    step(TMO + 5);
    expect_flags(32'h4, 0);
    sonar_echo = 1;
    measure(0, 0, 0, 1);
    step(TMO + 10);
    sonar_echo = 0;
    expect_flags(32'h4, 32'h00FF_FFFF);
`ifdef DMEM_IO_IRQ_EN
    measure(5, 40, 0, 3);
    chk("irq_set", {31'h0, irq}, 1);
    expect_flags(32'h2, 40);
    step();
    chk("irq_clr", {31'h0, irq}, 0);
`endif
    wr(3, 1);
    step(50);
    chk("trig_before_rst", {31'h0, sonar_trig}, 1);
    #2 reset = 0;
    #1 chk("trig_async_rst", {31'h0, sonar_trig}, 0);
    step();
    reset = 1;
    step();
    rd("ctrl_after_rst", BASE + 3, 1, 0);
    rd("result_after_rst", BASE + 4, 1, 0);
    rd("out_after_rst", BASE, 1, 0);
    rd("dir_after_rst", BASE + 1, 1, 0);
    step(3);
    if (sb_v.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d left want 0", sb_v.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
